// File: rtl/life_pkg.sv
// Shared types and helpers for the 8x8 Game-of-Life stepper.
// Holds the FSM state enum, board geometry and the cell-index helper.
package life_pkg;

  localparam int GRID_N    = 8;
  localparam int GRID_BITS = GRID_N * GRID_N;
  localparam int IDX_W     = $clog2(GRID_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } statetype;

  // Bit position of a cell: row 0 occupies bits 7:0.
  function automatic logic [IDX_W-1:0] idx(
    input int row,
    input int col
  );
    return IDX_W'(row * GRID_N + col);
  endfunction

endpackage

// File: rtl/life_stepper_if.sv
// Board/control bundle between the panel FSM, stepper and LED driver.
// master: seed/load/run/step out; grid/gen_count/tick/stable/extinct in.
interface life_stepper_if #(
  parameter int CNT_W = 16
);
  import life_pkg::*;

  logic [GRID_BITS-1:0] seed;
  logic                 load;
  logic                 run;
  logic                 step;
  logic [GRID_BITS-1:0] grid;
  logic [CNT_W-1:0]     gen_count;
  logic                 tick;
  logic                 stable;
  logic                 extinct;

  modport master (
    output seed, load, run, step,
    input  grid, gen_count, tick, stable, extinct
  );

  modport slave (
    input  seed, load, run, step,
    output grid, gen_count, tick, stable, extinct
  );

endinterface

// File: rtl/life_next.sv
// Combinational B3/S23 next generation: i_grid -> o_next (64 bits each).
// Border is dead by default; LIFE_WRAP_EN makes the board toroidal.
module life_next
  import life_pkg::*;
(
  input  logic [GRID_BITS-1:0] i_grid,
  output logic [GRID_BITS-1:0] o_next
);

  function automatic logic [3:0] nbrs(
    input logic [GRID_BITS-1:0] g,
    input int                   r,
    input int                   c
  );
    logic [3:0] n;
    int rr;
    int cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (dr != 0 || dc != 0) begin
`ifdef LIFE_WRAP_EN
          rr = (rr + GRID_N) % GRID_N;
          cc = (cc + GRID_N) % GRID_N;
          n = n + {3'b000, g[idx(rr, cc)]};
`else
          if (rr >= 0 && rr < GRID_N &&
              cc >= 0 && cc < GRID_N)
            n = n + {3'b000, g[idx(rr, cc)]};
`endif
        end
      end
    end
    return n;
  endfunction

  function automatic logic rule(
    input logic [3:0] n,
    input logic       alive
  );
    return (n == 4'd3) || (alive && n == 4'd2);
  endfunction

  always_comb begin
    o_next = '0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        o_next[idx(r, c)] =
          rule(nbrs(i_grid, r, c), i_grid[idx(r, c)]);
      end
    end
  end

endmodule

// File: rtl/life_stepper.sv
// Game-of-Life generation engine: holds the grid, paces or single-steps.
// Ports: clk, reset (sync, active-low), bus (slave: seed/load/run/step in;
// grid/gen_count/tick/stable/extinct out). LIFE_WRAP_EN: toroidal board.
module life_stepper
  import life_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int CNT_W    = 16
)(
  input logic           clk,
  input logic           reset,
  life_stepper_if.slave bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  statetype             r_state, w_state;
  logic [GRID_BITS-1:0] r_grid,  w_grid;
  logic [CNT_W-1:0]     r_cnt,   w_cnt;
  logic [DIV_W-1:0]     r_div,   w_div;
  logic                 r_tick,  w_tick;
  logic                 r_stable, w_stable;
  logic [GRID_BITS-1:0] w_next;
  logic                 w_upd;

  life_next u_next (
    .i_grid (r_grid),
    .o_next (w_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_HALT;
      r_grid   <= '0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_tick   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_grid   <= w_grid;
      r_cnt    <= w_cnt;
      r_div    <= w_div;
      r_tick   <= w_tick;
      r_stable <= w_stable;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_grid   = r_grid;
    w_cnt    = r_cnt;
    w_div    = r_div;
    w_tick   = 1'b0;
    w_stable = r_stable;
    w_upd    = 1'b0;

    if (bus.load) begin
      w_grid   = bus.seed;
      w_cnt    = '0;
      w_div    = '0;
      w_stable = 1'b0;
      w_state  = (bus.seed == '0) ? S_HALT : S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.run) begin
            w_state = S_RUN;
            w_div   = '0;
          end else if (bus.step) begin
            w_upd = 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.run) begin
            w_state = S_IDLE;
            w_div   = '0;
          end else if (r_div == DIV_LAST) begin
            w_div = '0;
            w_upd = 1'b1;
          end else begin
            w_div = r_div + 1'b1;
          end
        end
        S_HALT: ;
        default: w_state = S_HALT;
      endcase

      if (w_upd) begin
        w_grid   = w_next;
        w_tick   = 1'b1;
        w_stable = (w_next == r_grid);
        w_cnt    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        if (w_next == '0)
          w_state = S_HALT;
      end
    end
  end

  assign bus.grid      = r_grid;
  assign bus.gen_count = r_cnt;
  assign bus.tick      = r_tick;
  assign bus.stable    = r_stable;
  assign bus.extinct   = (r_grid == '0);

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper: two instances (fast 4-deep pacing
// with 4-bit counter, and 10-deep pacing with 16-bit counter).
module tb_life_stepper;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] LONE    = 64'h0000_0010_0000_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_E080_4000;
  localparam logic [63:0] COL0    = 64'h0101_0101_0101_0101;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic seen;
  logic [63:0] col_acc;
  logic [63:0] gexp [1:5];
  int   n;

  life_stepper_if #(.CNT_W(4))  ia ();
  life_stepper_if #(.CNT_W(16)) ib ();

  life_stepper #(.TICK_DIV(4), .CNT_W(4)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  life_stepper #(.TICK_DIV(10), .CNT_W(16)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    gexp[1] = 64'h0000_0040_C0A0_0000;
    gexp[2] = 64'h0000_00C0_A080_0000;
`ifdef LIFE_WRAP_EN
    gexp[3] = 64'h0000_00C0_8140_0000;
    gexp[4] = 64'h0000_00C1_0180_0000;
`else
    gexp[3] = 64'h0000_00C0_8040_0000;
    gexp[4] = 64'h0000_00C0_8000_0000;
`endif
    gexp[5] = 64'h0000_00C0_C000_0000;
    ia.seed = '0; ia.load = 0; ia.run = 0; ia.step = 0;
    ib.seed = '0; ib.load = 0; ib.run = 0; ib.step = 0;
    reset = 1'b0;
    cyc();
    cyc();
    chk("rst_grid",    ia.grid,      64'h0);
    chk("rst_gen",     ia.gen_count, 64'h0);
    chk("rst_tick",    ia.tick,      64'h0);
    chk("rst_stable",  ia.stable,    64'h0);
    chk("rst_extinct", ia.extinct,   64'h1);
    reset = 1'b1;
    ia.step = 1; cyc(); ia.step = 0;
    chk("rst_halt_step", ia.tick, 64'h0);

    // blinker, free-running
    ia.seed = BLINK_H; ia.load = 1; cyc(); ia.load = 0;
    chk("blk_load",    ia.grid,      BLINK_H);
    chk("blk_gen0",    ia.gen_count, 64'h0);
    chk("blk_extinct", ia.extinct,   64'h0);
    ia.run = 1; ia.step = 1; cyc(); ia.step = 0;
    chk("run_step_ign", ia.grid, BLINK_H);
    seen = 0;
    repeat (3) begin cyc(); seen |= ia.tick; end
    chk("blk_early", seen, 64'h0);
    cyc();
    chk("blk_g1",      ia.grid,      BLINK_V);
    chk("blk_g1_tick", ia.tick,      64'h1);
    chk("blk_g1_gen",  ia.gen_count, 64'h1);
    chk("blk_g1_stab", ia.stable,    64'h0);
    seen = 0;
    repeat (3) begin cyc(); seen |= ia.tick; end
    chk("blk_gap", seen, 64'h0);
    cyc();
    chk("blk_g2",      ia.grid,      BLINK_H);
    chk("blk_g2_tick", ia.tick,      64'h1);
    chk("blk_g2_gen",  ia.gen_count, 64'h2);
    chk("blk_g2_stab", ia.stable,    64'h0);
    ia.run = 0; cyc();
    chk("run_off_tick", ia.tick, 64'h0);
    chk("run_off_grid", ia.grid, BLINK_H);

    // block still-life
    ia.seed = BLOCK; ia.load = 1; cyc(); ia.load = 0;
    ia.step = 1; cyc(); ia.step = 0;
    chk("blkl_grid", ia.grid,      BLOCK);
    chk("blkl_stab", ia.stable,    64'h1);
    chk("blkl_gen",  ia.gen_count, 64'h1);
    chk("blkl_tick", ia.tick,      64'h1);
    cyc();
    chk("blkl_tick1", ia.tick, 64'h0);

    // lone cell dies, board halts
    ia.seed = LONE; ia.load = 1; cyc(); ia.load = 0;
    chk("load_clr_stab", ia.stable, 64'h0);
    ia.step = 1; cyc(); ia.step = 0;
    chk("lone_grid", ia.grid,      64'h0);
    chk("lone_ext",  ia.extinct,   64'h1);
    chk("lone_tick", ia.tick,      64'h1);
    chk("lone_gen",  ia.gen_count, 64'h1);
    seen = 0;
    ia.step = 1; cyc(); ia.step = 0; seen |= ia.tick;
    ia.run = 1;
    repeat (8) begin cyc(); seen |= ia.tick; end
    ia.run = 0;
    chk("halt_no_tick", seen,         64'h0);
    chk("halt_gen",     ia.gen_count, 64'h1);

    // load beats step
    ia.seed = BLINK_H; ia.load = 1; ia.step = 1; cyc();
    ia.load = 0; ia.step = 0;
    chk("ldstep_grid", ia.grid,      BLINK_H);
    chk("ldstep_tick", ia.tick,      64'h0);
    chk("ldstep_gen",  ia.gen_count, 64'h0);

    // zero seed halts
    ia.seed = '0; ia.load = 1; cyc(); ia.load = 0;
    ia.step = 1; cyc(); ia.step = 0;
    chk("zero_seed_halt", ia.tick, 64'h0);

    // glider against the east edge
    ia.seed = GLIDER; ia.load = 1; cyc(); ia.load = 0;
    col_acc = ia.grid;
    for (int i = 1; i <= 4; i++) begin
      ia.step = 1; cyc(); ia.step = 0;
      col_acc |= ia.grid;
      chk("glider", ia.grid, gexp[i]);
    end
`ifndef LIFE_WRAP_EN
    ia.step = 1; cyc(); ia.step = 0;
    col_acc |= ia.grid;
    chk("glider_block", ia.grid, gexp[5]);
    chk("glider_col0",  col_acc & COL0, 64'h0);
    ia.step = 1; cyc(); ia.step = 0;
    chk("glider_stab", ia.stable, 64'h1);
`endif

    // counter saturation then reset
    ia.seed = BLINK_H; ia.load = 1; cyc(); ia.load = 0;
    for (int i = 1; i <= 20; i++) begin
      ia.step = 1; cyc(); ia.step = 0; cyc();
      chk("sat_cnt", ia.gen_count, (i > 15) ? 64'd15 : 64'(i));
    end
    chk("sat_grid", ia.grid, BLINK_H);
    reset = 1'b0; ia.step = 1; cyc();
    reset = 1'b1; ia.step = 0;
    chk("rst2_grid", ia.grid,      64'h0);
    chk("rst2_gen",  ia.gen_count, 64'h0);
    chk("rst2_ext",  ia.extinct,   64'h1);
    chk("rst2_tick", ia.tick,      64'h0);

    // slow instance: run drop clears pacing
    ib.seed = BLINK_H; ib.load = 1; cyc(); ib.load = 0;
    ib.run = 1; seen = 0;
    repeat (6) begin cyc(); seen |= ib.tick; end
    ib.run = 0; cyc(); seen |= ib.tick;
    chk("b_partial", seen, 64'h0);
    ib.run = 1; n = 0;
    do begin cyc(); n++; end while (!ib.tick && n < 40);
    chk("b_rerun_lat", 64'(n), 64'd11);
    chk("b_rerun_grid", ib.grid, BLINK_V);

    // load mid-run at divider 7
    seen = 0;
    repeat (7) begin cyc(); seen |= ib.tick; end
    chk("b_mid_quiet", seen, 64'h0);
    ib.seed = BLOCK; ib.load = 1; cyc(); ib.load = 0;
    chk("b_mid_grid", ib.grid,      BLOCK);
    chk("b_mid_gen",  ib.gen_count, 64'h0);
    chk("b_mid_tick", ib.tick,      64'h0);
    n = 0;
    do begin cyc(); n++; end while (!ib.tick && n < 40);
    chk("b_mid_lat",  64'(n),       64'd11);
    chk("b_mid_gen1", ib.gen_count, 64'h1);
    chk("b_mid_stab", ib.stable,    64'h1);
    ib.run = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
